// File: rtl/seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : seg_scan_mux
// Desc    : Self-sequencing seven-segment digit scanner with tear-free code
//           shadowing, anode blanking guard and frame-start marker.
// Rev     : 1.0
// ============================================================================

module seg_scan_mux #(
  parameter  int DIGITS   = 8,
  parameter  int N        = 6,
  parameter  int TICK_DIV = 100000,
  parameter  int BLANK    = 4,
  localparam int IW       = $clog2(DIGITS)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [DIGITS*N-1:0] w,
  input  logic [DIGITS-1:0]   en,
  output logic [N-1:0]        f,
  output logic [DIGITS-1:0]   an,
  output logic [IW-1:0]       sel,
  output logic                frame
);

  localparam int              CW        = $clog2(TICK_DIV);
  localparam logic [CW-1:0]   c_last    = CW'(TICK_DIV - 1);
  localparam logic [CW-1:0]   c_blank   = CW'(BLANK);
  localparam logic [CW-1:0]   c_one     = CW'(1);
  localparam logic [IW:0]     c_digits  = (IW + 1)'(DIGITS);
  localparam logic [IW-1:0]   c_sel_rst = IW'(DIGITS - 1);

  logic [N-1:0]      w_code [DIGITS];
  logic [CW-1:0]     r_cnt;
  logic              w_boundary;
  logic [CW-1:0]     w_cnt_nxt;
  logic [IW:0]       w_idx;
  logic              w_found;
  logic [IW-1:0]     w_scan_sel;
  logic [IW-1:0]     w_sel_nxt;
  logic [DIGITS-1:0] w_an_nxt;
  logic              w_frame_nxt;

  for (genvar k = 0; k < DIGITS; k++) begin : g_slice
    assign w_code[k] = w[k*N +: N];
  end

  assign w_boundary = (r_cnt == c_last);
  assign w_cnt_nxt  = w_boundary ? '0 : r_cnt + c_one;

  // Circular search starting just after the current digit; the last probe
  // lands on sel itself, so a lone enabled digit keeps being selected.
  always_comb begin
    w_scan_sel = sel;
    w_found    = 1'b0;
    w_idx      = '0;
    for (int i = 1; i <= DIGITS; i++) begin
      w_idx = {1'b0, sel} + (IW + 1)'(i);
      if (w_idx >= c_digits) begin
        w_idx = w_idx - c_digits;
      end
      if (!w_found && en[w_idx[IW-1:0]]) begin
        w_scan_sel = w_idx[IW-1:0];
        w_found    = 1'b1;
      end
    end
  end

  assign w_sel_nxt   = w_boundary ? w_scan_sel : sel;
  assign w_frame_nxt = w_boundary && (w_scan_sel <= sel) && (|en);

  always_comb begin
    w_an_nxt = '1;
    if ((w_cnt_nxt >= c_blank) && en[w_sel_nxt]) begin
      w_an_nxt[w_sel_nxt] = 1'b0;
    end
  end

  // Code is shadowed only at slot start so a slot never shows a torn value.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= c_last;
      sel   <= c_sel_rst;
      f     <= '0;
      an    <= '1;
      frame <= 1'b0;
    end else begin
      r_cnt <= w_cnt_nxt;
      sel   <= w_sel_nxt;
      if (w_boundary) begin
        f <= w_code[w_sel_nxt];
      end
      an    <= w_an_nxt;
      frame <= w_frame_nxt;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_seg_scan_mux.sv
`default_nettype none
// ============================================================================
// Module  : tb_seg_scan_mux
// Desc    : Self-checking bench for seg_scan_mux against a slot/queue model.
// Rev     : 1.0
// ============================================================================

module tb_seg_scan_mux;

  localparam int DIGITS   = 4;
  localparam int N        = 6;
  localparam int TICK_DIV = 8;
  localparam int BLANK    = 2;
  localparam int IW       = 2;
  localparam int VW       = IW + N + DIGITS + 1;

  logic                clk     = 1'b0;
  logic                reset_n = 1'b1;
  logic [DIGITS*N-1:0] w       = '0;
  logic [DIGITS-1:0]   en      = '0;
  logic [N-1:0]        f;
  logic [DIGITS-1:0]   an;
  logic [IW-1:0]       sel;
  logic                frame;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: position within slot, scanned digit, expected outputs.
  int              m_pos;
  int              m_sel;
  logic [N-1:0]    m_f;
  logic [DIGITS-1:0] m_an;
  logic            m_frame;

  seg_scan_mux #(
    .DIGITS  (DIGITS),
    .N       (N),
    .TICK_DIV(TICK_DIV),
    .BLANK   (BLANK)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .w      (w),
    .en     (en),
    .f      (f),
    .an     (an),
    .sel    (sel),
    .frame  (frame)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] got_vec();
    return {sel, f, an, frame};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    return {IW'(m_sel), m_f, m_an, m_frame};
  endfunction

  task automatic model_reset();
    m_pos   = TICK_DIV - 1;
    m_sel   = DIGITS - 1;
    m_f     = '0;
    m_an    = '1;
    m_frame = 1'b0;
  endtask

  // Advance model with the inputs present before the edge, then clock once.
  task automatic tick();
    int q[$];
    int nxt;
    m_frame = 1'b0;
    if (m_pos == TICK_DIV - 1) begin
      m_pos = 0;
      for (int d = 0; d < DIGITS; d++) if (en[d]) q.push_back(d);
      if (q.size() != 0) begin
        nxt = q[0];
        for (int k = q.size() - 1; k >= 0; k--) if (q[k] > m_sel) nxt = q[k];
        m_frame = (nxt <= m_sel);
        m_sel   = nxt;
      end
      m_f = w[m_sel*N +: N];
    end else begin
      m_pos++;
    end
    m_an = '1;
    if (m_pos >= BLANK && en[m_sel]) m_an[m_sel] = 1'b0;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic tick_until(input int s, input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 64 && !ok; i++) begin
      if (m_sel == s && m_pos == p) ok = 1'b1;
      else tick();
    end
    if (m_sel == s && m_pos == p) ok = 1'b1;
  endtask

  task automatic test_reset();
    w  = {6'h03, 6'h02, 6'h01, 6'h00};
    en = 4'hF;
    #1 reset_n = 1'b0;
    #12;
    n_checks++; if (an !== 4'hF)  begin n_fail++; $display("FAIL reset_an got=%b exp=1111", an); end
    n_checks++; if (sel !== 2'd3) begin n_fail++; $display("FAIL reset_sel got=%0d exp=3", sel); end
    n_checks++; if (f !== 6'h00)  begin n_fail++; $display("FAIL reset_f got=%h exp=00", f); end
    n_checks++; if (frame !== 1'b0) begin n_fail++; $display("FAIL reset_frame got=%b exp=0", frame); end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_scan_all();
    logic [DIGITS-1:0] ea;
    int s, p;
    for (int i = 0; i < 40; i++) begin
      tick();
      s = i / TICK_DIV;
      p = i % TICK_DIV;
      ea = 4'hF;
      if (p >= BLANK) ea[s % 4] = 1'b0;
      n_checks++;
      if (sel !== IW'(s % 4) || f !== N'(s % 4) || an !== ea || frame !== (p == 0 && s % 4 == 0)) begin
        n_fail++;
        $display("FAIL scan_all i=%0d got sel=%0d f=%h an=%b frame=%b exp sel=%0d f=%h an=%b frame=%b",
                 i, sel, f, an, frame, s % 4, s % 4, ea, (p == 0 && s % 4 == 0));
      end
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL scan_all_model i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_en_1010();
    en = 4'b1010;
    for (int i = 0; i < 32; i++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec() || an[0] !== 1'b1 || an[2] !== 1'b1) begin
        n_fail++; $display("FAIL en_1010 i=%0d got=%h exp=%h an=%b", i, got_vec(), exp_vec(), an);
      end
    end
  endtask

  task automatic test_single();
    en = 4'b0100;
    for (int i = 0; i < 24; i++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL single i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
    en = 4'b0000;
    for (int i = 0; i < 16; i++) begin
      tick();
      n_checks++;
      if (got_vec() !== exp_vec() || an !== 4'hF || frame !== 1'b0 || sel !== 2'd2) begin
        n_fail++; $display("FAIL none_en i=%0d got=%h exp=%h", i, got_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_w_midslot();
    bit ok;
    en = 4'hF;
    w  = {6'h03, 6'h02, 6'h01, 6'h00};
    tick_until(1, 0, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL w_sync got=timeout exp=sel1"); end
    for (int i = 0; i < 4; i++) tick();
    w[1*N +: N] = 6'h2A;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (f !== 6'h01 || got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL w_hold i=%0d got f=%h exp f=01", i, f);
      end
    end
    tick_until(1, 0, ok);
    n_checks++;
    if (!ok || f !== 6'h2A || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL w_update got f=%h exp f=2a", f);
    end
  endtask

  task automatic test_en_drop();
    bit ok;
    en = 4'hF;
    tick_until(1, 5, ok);
    n_checks++; if (!ok) begin n_fail++; $display("FAIL drop_sync got=timeout exp=sel1"); end
    en[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      n_checks++;
      if (an !== 4'hF || sel !== 2'd1 || got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL drop_hold i=%0d got an=%b sel=%0d exp an=1111 sel=1", i, an, sel);
      end
    end
    tick();
    n_checks++;
    if (sel !== 2'd2 || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL drop_jump got sel=%0d exp sel=2", sel);
    end
  endtask

  task automatic test_reset_midslot();
    bit ok;
    en = 4'b0110;
    tick_until(2, 5, ok);
    n_checks++;
    if (!ok || an !== 4'b1011) begin
      n_fail++; $display("FAIL rst_sync got an=%b exp an=1011", an);
    end
    #2 reset_n = 1'b0;
    #1;
    n_checks++;
    if (an !== 4'hF || f !== 6'h00 || frame !== 1'b0 || sel !== 2'd3) begin
      n_fail++; $display("FAIL rst_async got an=%b f=%h frame=%b sel=%0d exp 1111/00/0/3", an, f, frame, sel);
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    tick();
    n_checks++;
    if (sel !== 2'd1 || frame !== 1'b1 || an !== 4'hF || f !== w[1*N +: N] || got_vec() !== exp_vec()) begin
      n_fail++; $display("FAIL rst_first got sel=%0d frame=%b an=%b exp sel=1 frame=1 an=1111", sel, frame, an);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) w = {$urandom, $urandom};
      if ($urandom_range(0, 15) == 0) en = DIGITS'($urandom);
      tick();
      n_checks++;
      if (got_vec() !== exp_vec()) begin
        n_fail++; $display("FAIL random i=%0d en=%b got=%h exp=%h", i, en, got_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_scan_all();
    test_en_1010();
    test_single();
    test_w_midslot();
    test_en_drop();
    test_reset_midslot();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule

`default_nettype wire
